// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: in-order instruction prefetch queue between imem and decode, with redirect flush and
// drop accounting for requests still in flight when the queue is flushed.
module if_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);
  localparam int AW = $clog2(DEPTH);
  // Extra headroom: back-to-back redirects can stack drops beyond one queue's worth.
  localparam int CW = AW + 2;
  logic [63:0]    pc_q [DEPTH];
  logic [31:0]    inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]  cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [63:0]    fpc_q, fpc_d;
  logic           alloc, pop, fill, rsp_live;

  assign imem_req_valid = resetn & (cnt_q < CW'(DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = fpc_q;
  assign id_valid       = filled_q[head_q] & ~redirect_valid;
  assign id_pc          = pc_q[head_q];
  assign id_inst        = inst_q[head_q];
  assign alloc          = imem_req_valid & imem_req_ready;
  assign pop            = id_valid & id_ready;
  assign rsp_live       = imem_rsp_valid & ((drop_q != '0) | (out_q != '0));
  assign fill           = imem_rsp_valid & ~redirect_valid & (drop_q == '0) & (out_q != '0);

  always_comb begin
    head_d = redirect_valid ? '0 : head_q + AW'(pop);
    tail_d = redirect_valid ? '0 : tail_q + AW'(alloc);
    fill_d = redirect_valid ? '0 : fill_q + AW'(fill);
    cnt_d  = redirect_valid ? '0 : cnt_q + CW'(alloc) - CW'(pop);
    out_d  = redirect_valid ? '0 : out_q + CW'(alloc) - CW'(fill);
    // A response arriving on the redirect edge retires one in-flight request right away.
    drop_d = redirect_valid ? drop_q + out_q - CW'(rsp_live)
                            : drop_q - CW'(imem_rsp_valid && (drop_q != '0));
    fpc_d  = redirect_valid ? (redirect_pc & ~64'd3) : fpc_q + (alloc ? 64'd4 : 64'd0);
    filled_d = filled_q;
    if (redirect_valid) filled_d = '0;
    else begin
      if (alloc) filled_d[tail_q] = 1'b0;
      if (fill) filled_d[fill_q] = 1'b1;
      if (pop) filled_d[head_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      fpc_q    <= RESET_PC;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      fpc_q    <= fpc_d;
      filled_q <= filled_d;
      if (alloc) pc_q[tail_q] <= fpc_q;
      if (fill) inst_q[fill_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: directed scenarios against an in-order latency memory model and a queue of
// expected fetch PCs that each decoded instruction is checked against.
module tb_if_prefetch_buffer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;

  int vectors = 0, errs = 0, cyc = 0, lat = 1, req_cnt = 0, pop_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mq_a[$];
  int          mq_d[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr = '0;

  if_prefetch_buffer #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [63:0] s);
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back(s + 64'(4 * i));
  endtask

  // Called at posedge+1; returns at posedge+2 of the following cycle.
  task automatic do_redirect(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    push_run(t & ~64'd3);
    #1;
    chk("rd_id_valid", 64'(id_valid), 64'd0);
    chk("rd_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_next_req", 64'(imem_req_valid), 64'd1);
    chk("rd_next_addr", imem_req_addr, t & ~64'd3);
    chk("rd_next_id", 64'(id_valid), 64'd0);
  endtask

  // Memory model and decode-side scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e;
    cyc++;
    if (!resetn) begin
      mq_a.delete();
      mq_d.delete();
      imem_rsp_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !redirect_valid) begin
        chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
        chk("req_hold_addr", imem_req_addr, prev_addr);
      end
      prev_stall = imem_req_valid & ~imem_req_ready;
      prev_addr = imem_req_addr;
      if (id_valid && id_ready) begin
        pop_cnt++;
        chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_inst", 64'(id_inst), 64'(f(e)));
        end
      end
      if (mq_d.size() > 0 && mq_d[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = f(mq_a[0]);
        void'(mq_a.pop_front());
        void'(mq_d.pop_front());
      end else imem_rsp_valid = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        req_cnt++;
        mq_a.push_back(imem_req_addr);
        mq_d.push_back(cyc + lat);
      end
    end
  end

  initial begin
    int p;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_id_inst", 64'(id_inst), 64'd0);
    tick();
    resetn = 1'b1;
    push_run(64'h0);
    #1;
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_req_addr, 64'h0);
    // decode stalled: queue fills to DEPTH and fetching stops
    repeat (10) tick();
    chk("stall_req_cnt", 64'(req_cnt), 64'd4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_id_valid", 64'(id_valid), 64'd1);
    chk("stall_id_pc", id_pc, 64'h0);
    chk("stall_id_inst", 64'(id_inst), 64'(f(64'h0)));
    repeat (3) tick();
    chk("stall_hold_pc", id_pc, 64'h0);
    id_ready = 1'b1;
    repeat (5) tick();
    p = pop_cnt;
    repeat (10) tick();
    chk("stream_rate", 64'(pop_cnt - p), 64'd10);
    // redirect with three requests in flight at 3-cycle latency
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = (mq_a.size() == 3);
    end
    chk("wait_3_outstanding", 64'(found), 64'd1);
    do_redirect(64'h100);
    p = pop_cnt;
    repeat (20) tick();
    chk("post_redirect_progress", 64'(pop_cnt > p), 64'd1);
    // redirect landing on a response and a would-be pop
    lat = 2;
    repeat (10) tick();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = mq_d.size() > 0 && mq_d[0] <= cyc + 1 && id_valid;
    end
    chk("wait_coincident", 64'(found), 64'd1);
    p = pop_cnt;
    do_redirect(64'h200);
    chk("coinc_rsp_seen", 64'(imem_rsp_valid), 64'd1);
    chk("coinc_no_pop", 64'(pop_cnt), 64'(p));
    p = pop_cnt;
    repeat (20) tick();
    chk("coinc_progress", 64'(pop_cnt > p), 64'd1);
    // request backpressure and a misaligned redirect target
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      imem_req_ready = i[0];
    end
    tick();
    do_redirect(64'h10A);
    p = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      imem_req_ready = i[0];
    end
    chk("bp_progress", 64'(pop_cnt > p), 64'd1);
    imem_req_ready = 1'b1;
    // asynchronous reset mid-stream
    repeat (5) tick();
    chk("pre_rst_id_valid", 64'(id_valid), 64'd1);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("async_req_valid", 64'(imem_req_valid), 64'd0);
    chk("async_id_valid", 64'(id_valid), 64'd0);
    chk("async_id_pc", id_pc, 64'd0);
    chk("async_id_inst", 64'(id_inst), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    push_run(64'h0);
    #1;
    chk("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    chk("post_rst_req_addr", imem_req_addr, 64'h0);
    p = pop_cnt;
    repeat (15) tick();
    chk("post_rst_progress", 64'(pop_cnt > p), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
